// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner of the shared four-input data mux.
//
// One requester at a time owns the mux. The owner keeps it for up to MAX_BURST
// valid/ready transfers, or until it drops its request. Every release costs one
// idle cycle, and the next scan starts just after the previous owner.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req        request per source; bit i belongs to data_in(i+1)
//   data_in1-4 source data, WIDTH bits each
//   out_ready  downstream accepts data_out this cycle
//   grant      registered one-hot owner, 0 when idle
//   select     registered mux select (index of the owner)
//   data_out   combinational mux output, 0 when idle
//   out_valid  owner is granted and still requesting
module rr_mux_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [WIDTH-1:0] data_in3,
    input  logic [WIDTH-1:0] data_in4,
    input  logic             out_ready,
    output logic [3:0]       grant,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    // Four bits hold the whole legal MAX_BURST range (1..15).
    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST);

    logic [0:0]      state_q, state_d;
    logic [1:0]      select_q, select_d;
    logic [3:0]      grant_q, grant_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            found;
    logic [1:0]      pick_idx;
    logic [1:0]      cand;
    logic [CntW-1:0] cnt_inc;
    logic            owner_req;
    logic [WIDTH-1:0] mux_out;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        found    = 1'b0;
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign owner_req = req[select_q];
    assign cnt_inc   = cnt_q + CntW'(1);

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d  = StGrant;
                    select_d = pick_idx;
                    grant_d  = 4'b0001 << pick_idx;
                    cnt_d    = '0;
                end
            end
            StGrant: begin
                // Withdrawal wins over a stalled or completing transfer; either
                // way it is a single release and ptr advances once.
                if (!owner_req || (out_ready && cnt_inc == BurstMax)) begin
                    state_d = StIdle;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = select_q + 2'd1;
                end else if (out_ready) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            select_q <= '0;
            grant_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        mux_out = '0;
        case (select_q)
            2'd0:    mux_out = data_in1;
            2'd1:    mux_out = data_in2;
            2'd2:    mux_out = data_in3;
            2'd3:    mux_out = data_in4;
            default: mux_out = '0;
        endcase
    end

    assign data_out  = (state_q == StGrant) ? mux_out : '0;
    assign out_valid = (state_q == StGrant) && owner_req;
    assign grant     = grant_q;
    assign select    = select_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized and directed bench for rr_mux_arbiter. A behavioural model of the
// arbitration rules predicts the outputs of every cycle; the stimulus process
// queues the prediction and a separate monitor pops it and compares it with the
// DUT at the falling edge.
module tb_rr_mux_arbiter;

    localparam int MAXB = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] d [4];
    logic        out_ready;
    logic [3:0]  grant;
    logic [1:0]  select;
    logic [31:0] data_out;
    logic        out_valid;

    rr_mux_arbiter #(.WIDTH(32), .MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in1  (d[0]),
        .data_in2  (d[1]),
        .data_in3  (d[2]),
        .data_in4  (d[3]),
        .out_ready (out_ready),
        .grant     (grant),
        .select    (select),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic        valid;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   running = 0;
    bit   fix_d2 = 0;

    // Model state: owner index (-1 when nobody owns the mux), transfers done in
    // this grant, where the next scan starts and the last select shown.
    int m_owner, m_taken, m_next, m_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_taken = 0; m_next = 0; m_sel = 0;
    endtask

    // Advance the model over one rising edge with the inputs seen at that edge.
    task automatic model_step(input logic [3:0] r, input logic rdy);
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_next + k) % 4;
                if (m_owner < 0 && r[j]) begin
                    m_owner = j; m_sel = j; m_taken = 0;
                end
            end
        end else begin
            bit rel;
            rel = 0;
            if (!r[m_owner]) rel = 1;
            else if (rdy) begin
                m_taken++;
                if (m_taken == MAXB) rel = 1;
            end
            if (rel) begin
                m_next = (m_owner + 1) % 4; m_owner = -1; m_taken = 0;
            end
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e.sel   = 2'(m_sel);
        e.valid = (m_owner >= 0) && req[m_owner];
        e.data  = (m_owner < 0) ? 32'h0 : d[m_owner];
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] r, input logic rdy);
        @(posedge clk);
        model_step(req, out_ready);
        #1;
        req = r;
        out_ready = rdy;
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        if (fix_d2) d[1] = 32'hA5A5_0001;
        push_expect();
        running = 1;
    endtask

    // Pulse reset between edges and check the outputs while it is asserted.
    task automatic reset_pulse();
        @(posedge clk);
        model_step(req, out_ready);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_select", 32'(select), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", data_out, 32'h0);
        #2;
        rst = 1'b0;
        push_expect();
    endtask

    always @(negedge clk) begin
        if (running) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("grant", 32'(grant), 32'(e.grant));
                check("select", 32'(select), 32'(e.sel));
                check("out_valid", 32'(out_valid), 32'(e.valid));
                check("data_out", data_out, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        model_reset();
        #12;
        check("init_grant", 32'(grant), 32'h0);
        check("init_select", 32'(select), 32'h0);
        check("init_valid", 32'(out_valid), 32'h0);
        check("init_data", data_out, 32'h0);
        rst = 1'b0;

        // Single source with a fixed data word: bursts of 4 with 1-cycle gaps.
        fix_d2 = 1;
        for (int i = 0; i < 12; i++) drive(4'b0010, 1'b1);
        fix_d2 = 0;
        for (int i = 0; i < 2; i++) drive(4'b0000, 1'b1);

        // Fairness: all requesting.
        for (int i = 0; i < 26; i++) drive(4'b1111, 1'b1);

        // Idle output with changing data.
        for (int i = 0; i < 4; i++) drive(4'b0000, 1'b1);

        // Backpressure on source 0.
        for (int i = 0; i < 6; i++) drive(4'b0001, 1'b0);
        for (int i = 0; i < 6; i++) drive(4'b0001, 1'b1);
        for (int i = 0; i < 2; i++) drive(4'b0000, 1'b1);

        // Early withdrawal of source 2 with source 0 pending.
        for (int i = 0; i < 3; i++) drive(4'b0101, 1'b1);
        for (int i = 0; i < 6; i++) drive(4'b0001, 1'b1);
        for (int i = 0; i < 2; i++) drive(4'b0000, 1'b1);

        // Owner drops req while stalled.
        for (int i = 0; i < 3; i++) drive(4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) drive(4'b0000, 1'b0);

        // Async reset mid-burst on source 3, then a full burst again.
        for (int i = 0; i < 3; i++) drive(4'b1000, 1'b1);
        reset_pulse();
        for (int i = 0; i < 8; i++) drive(4'b1000, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = 4'($urandom);
            if ($urandom_range(0, 7) == 0) r = 4'b0000;
            drive(r, $urandom_range(0, 9) < 7);
        end

        @(negedge clk);
        #1;
        running = 0;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
